// File: rtl/seven_segment_scan_ctrl_pkg.sv
// ============================================================================
// Module : seven_segment_scan_ctrl_pkg
// Brief  : Shared types and helpers for the seven-segment scan controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seven_segment_scan_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seven_segment_scan_ctrl_seg_slot_timer.sv
// ============================================================================
// Module : seg_slot_timer
// Brief  : Free-running digit-slot counter with blank-end / slot-end strobes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seg_slot_timer
    import seven_segment_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    output logic blank_end,
    output logic slot_pre_end,
    output logic slot_end
);

    localparam int            CW           = clog2_min1(REFRESH_DIV);
    localparam logic [CW-1:0] c_blank_last = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] c_pre_last   = CW'(REFRESH_DIV - 2);
    localparam logic [CW-1:0] c_slot_last  = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // One cycle early so the parent can register its frame marker.
    assign blank_end    = (cnt_q == c_blank_last);
    assign slot_pre_end = (cnt_q == c_pre_last);
    assign slot_end     = (cnt_q == c_slot_last);

endmodule

`default_nettype wire

// File: rtl/seven_segment_scan_ctrl.sv
// ============================================================================
// Module : seven_segment_scan_ctrl
// Brief  : Multiplexed seven-segment scanner with blanking, LZS and
//          frame-synchronous double-buffered display data.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seven_segment_scan_ctrl
    import seven_segment_scan_ctrl_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int N            = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS*N-1:0]   din,
    input  logic                  load,
    input  logic                  lzs_en,
    output logic                  load_ack,
    output logic [N-1:0]          value,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int            DW           = clog2_min1(DIGITS);
    localparam logic [N-1:0]  BLANK_CODE   = '1;
    localparam logic [DW-1:0] c_last_digit = DW'(DIGITS - 1);

    scan_state_e           state_q, state_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic [DIGITS*N-1:0]   disp_q, disp_d;
    logic [DIGITS*N-1:0]   pend_q, pend_d;
    logic                  pend_v_q, pend_v_d;
    logic                  load_ack_q, load_ack_d;
    logic                  frame_tick_q, frame_tick_d;
    logic [N-1:0]          value_q, value_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic                  w_blank_end;
    logic                  w_slot_pre_end;
    logic                  w_slot_end;
    logic [N-1:0]          w_code;
    logic [DIGITS-1:0]     w_an_sel;
    logic                  w_upper_zero;

    seg_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk          (clk),
        .rst          (rst),
        .blank_end    (w_blank_end),
        .slot_pre_end (w_slot_pre_end),
        .slot_end     (w_slot_end)
    );

    // Digit code for the current index; blanked if it and everything above is zero.
    always_comb begin
        w_code       = '0;
        w_upper_zero = 1'b1;
        w_an_sel     = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (DW'(i) == digit_q) begin
                w_code      = disp_q[i*N +: N];
                w_an_sel[i] = 1'b0;
            end
            if ((DW'(i) >= digit_q) && (disp_q[i*N +: N] != '0)) begin
                w_upper_zero = 1'b0;
            end
        end
        if (lzs_en && (digit_q != '0) && w_upper_zero) begin
            w_code = BLANK_CODE;
        end
    end

    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        an_d         = an_q;
        value_d      = value_q;
        frame_tick_d = w_slot_pre_end && (digit_q == c_last_digit);
        case (state_q)
            ST_BLANK: begin
                if (w_blank_end) begin
                    state_d = ST_DRIVE;
                    an_d    = w_an_sel;
                    value_d = w_code;
                end
            end
            ST_DRIVE: begin
                if (w_slot_end) begin
                    state_d = ST_BLANK;
                    digit_d = (digit_q == c_last_digit) ? '0 : digit_q + DW'(1);
                    an_d    = '1;
                    value_d = BLANK_CODE;
                end
            end
            default: begin
                state_d = ST_BLANK;
                an_d    = '1;
                value_d = BLANK_CODE;
            end
        endcase
    end

    // A load on the commit cycle goes straight to the display buffer.
    always_comb begin
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        disp_d     = disp_q;
        load_ack_d = 1'b0;
        if (load) begin
            pend_d   = din;
            pend_v_d = 1'b1;
        end
        if (frame_tick_q && (pend_v_q || load)) begin
            disp_d     = load ? din : pend_q;
            pend_v_d   = 1'b0;
            load_ack_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            digit_q      <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            load_ack_q   <= 1'b0;
            frame_tick_q <= 1'b0;
            value_q      <= BLANK_CODE;
            an_q         <= '1;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            load_ack_q   <= load_ack_d;
            frame_tick_q <= frame_tick_d;
            value_q      <= value_d;
            an_q         <= an_d;
        end
    end

    assign load_ack   = load_ack_q;
    assign value      = value_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scan_ctrl.sv
// ============================================================================
// Module : tb_seven_segment_scan_ctrl
// Brief  : Scoreboard bench for seven_segment_scan_ctrl against a timeline model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seven_segment_scan_ctrl;

    localparam int D  = 4;
    localparam int NB = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [D*NB-1:0]   din = '0;
    logic              load = 1'b0;
    logic              lzs_en = 1'b0;
    logic              load_ack;
    logic [NB-1:0]     value;
    logic [D-1:0]      an;
    logic              frame_tick;

    seven_segment_scan_ctrl #(
        .DIGITS       (D),
        .N            (NB),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load       (load),
        .lzs_en     (lzs_en),
        .load_ack   (load_ack),
        .value      (value),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [D-1:0]  an;
        logic [NB-1:0] value;
        logic          ft;
        logic          ack;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    // Model: cycle index since reset release plus buffer contents.
    int              t;
    logic [D*NB-1:0] m_disp;
    logic [D*NB-1:0] m_pend;
    bit              m_pend_v;
    bit              m_ack;
    logic [NB-1:0]   m_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    function automatic logic [NB-1:0] ref_code(input logic [D*NB-1:0] disp, input int idx, input bit lz);
        int msd;
        msd = -1;
        for (int j = 0; j < D; j++) begin
            if (disp[j*NB +: NB] != 0) msd = j;
        end
        if (lz && idx != 0 && idx > msd) return '1;
        return disp[idx*NB +: NB];
    endfunction

    task automatic model_reset();
        t        = 0;
        m_disp   = '0;
        m_pend   = '0;
        m_pend_v = 1'b0;
        m_ack    = 1'b0;
        m_lat    = '1;
    endtask

    function automatic bit at_tick();
        return ((t % RD) == RD - 1) && (((t / RD) % D) == D - 1);
    endfunction

    // Called at posedge+1: predicts this cycle, drives inputs, advances the model.
    task automatic step(input bit ld, input logic [D*NB-1:0] d, input bit lz);
        int   pos;
        int   dig;
        exp_t e;
        pos     = t % RD;
        dig     = (t / RD) % D;
        e.an    = (pos >= BC) ? ~(D'(1) << dig) : '1;
        e.value = (pos >= BC) ? m_lat : '1;
        e.ft    = (pos == RD - 1) && (dig == D - 1);
        e.ack   = m_ack;
        sb_q.push_back(e);
        load   = ld;
        din    = d;
        lzs_en = lz;
        if (pos == BC - 1) m_lat = ref_code(m_disp, dig, lz);
        m_ack = 1'b0;
        if (e.ft && (m_pend_v || ld)) begin
            m_disp   = ld ? d : m_pend;
            m_pend_v = 1'b0;
            m_ack    = 1'b1;
        end else if (ld) begin
            m_pend   = d;
            m_pend_v = 1'b1;
        end
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to_tick(input bit lz);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 4 * D * RD; k++) begin
            if (at_tick()) begin
                found = 1'b1;
                break;
            end
            step(1'b0, '0, lz);
        end
        check("tick_reached", 32'(found), 32'd1);
    endtask

    function automatic logic [D*NB-1:0] sparse_digits();
        logic [D*NB-1:0] d;
        d = '0;
        for (int j = 0; j < D; j++) begin
            if ($urandom_range(0, 1) == 1) d[j*NB +: NB] = NB'($urandom);
        end
        return d;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow at %0t: actual=empty required=entry", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("an", 32'(an), 32'(mon_e.an));
                check("value", 32'(value), 32'(mon_e.value));
                check("frame_tick", 32'(frame_tick), 32'(mon_e.ft));
                check("load_ack", 32'(load_ack), 32'(mon_e.ack));
                check("an_one_low", 32'($countones(~an) <= 1), 32'd1);
            end
        end
    end

    initial begin
        bit found;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_value", 32'(value), 32'hF);
        check("rst_load_ack", 32'(load_ack), 32'd0);
        check("rst_frame_tick", 32'(frame_tick), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // First frame shows zeros, then a mid-frame load lands at the next frame.
        repeat (5) step(1'b0, '0, 1'b0);
        step(1'b1, 16'h1234, 1'b0);
        repeat (2 * D * RD) step(1'b0, '0, 1'b0);

        // Leading-zero suppression.
        step(1'b1, 16'h0050, 1'b1);
        repeat (2 * D * RD) step(1'b0, '0, 1'b1);
        step(1'b1, 16'h0000, 1'b1);
        repeat (2 * D * RD) step(1'b0, '0, 1'b1);

        // Load on the commit cycle overrides the pending value.
        step(1'b1, 16'hAAAA, 1'b0);
        advance_to_tick(1'b0);
        step(1'b1, 16'h1111, 1'b0);
        repeat (2 * D * RD) step(1'b0, '0, 1'b0);

        // Random traffic.
        repeat (800) begin
            if ($urandom_range(0, 1) == 1)
                step(($urandom_range(0, 9) == 0), sparse_digits(), 1'($urandom_range(0, 1)));
            else
                step(($urandom_range(0, 9) == 0), D*NB'($urandom), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-DRIVE of digit 2 with data still pending.
        advance_to_tick(1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, 16'h9876, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 4 * D * RD; k++) begin
            if (((t / RD) % D) == 2 && (t % RD) == BC + 2) begin
                found = 1'b1;
                break;
            end
            step(1'b0, '0, 1'b0);
        end
        check("digit2_reached", 32'(found), 32'd1);
        check("pre_rst_an", 32'(an), 32'hB);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        sb_q.delete();
        #1;
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_value", 32'(value), 32'hF);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (3 * D * RD) step(1'b0, '0, 1'b0);

        mon_en = 1'b0;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
